// File: rtl/uart_pkg.sv
// Shared types for the UART transmit/receive blocks.
// Optional break support is compiled in with UART_TX_BREAK_EN.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2,
        PAR_RSVD = 2'd3
    } parity_mode_t;

`ifdef UART_TX_BREAK_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK, MARK} tx_state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
`endif

    // The reserved encoding behaves like "no parity".
    function automatic logic parity_enabled(input parity_mode_t mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer shared by the UART transmitter and receiver.
// tick pulses on the last clock of every divisor-clock bit period; a divisor
// of 0 behaves like 1. While clear is high the count is held at zero so
// the first period after clear is released is a full one.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [DIV_W-1:0] divisor,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] last;

    assign last = (divisor == '0) ? '0 : divisor - DIV_W'(1);
    // >= rather than == so the count can never run past the terminal value
    assign tick = !clear && (cnt >= last);

    // Up-count within one bit period, restart on clear or at the period end
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (clear || tick)
            cnt <= '0;
        else
            cnt <= cnt + DIV_W'(1);
    end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: DATA_W data bits LSB first, runtime parity
// and stop-bit selection, valid/ready input handshake.
// Define UART_TX_BREAK_EN to add the send_break input (line break + mark).
//
// state  | meaning
// IDLE   | line high, ready to accept a character
// START  | start bit (low) for D clocks
// DATA   | DATA_W data bits, LSB first, D clocks each
// PARITY | parity bit for D clocks (skipped when parity is off)
// STOP   | 1 or 2 stop bits (high); tx_done on the last clock
// BREAK  | line held low while send_break is asserted
// MARK   | one D-clock high period after a break
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  parity_mode_t      parity_mode,
    input  logic              stop_sel,
    input  logic [DIV_W-1:0]  baud_divisor,
`ifdef UART_TX_BREAK_EN
    input  logic              send_break,
`endif
    output logic              tx_out,
    output logic              busy,
    output logic              tx_done
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    tx_state_t         state;
    logic [DATA_W-1:0] shift_q;
    logic              par_bit_q;
    logic              par_en_q;
    logic              stop2_q;
    logic [DIV_W-1:0]  div_q;
    logic [CNT_W-1:0]  bit_cnt;
    logic              tick;
    logic              baud_clear;
    logic              accept;

`ifdef UART_TX_BREAK_EN
    assign in_ready = (state == IDLE) && !reset && !send_break;
`else
    assign in_ready = (state == IDLE) && !reset;
`endif
    assign accept = in_valid && in_ready;
    assign busy   = (state != IDLE);
    // In STOP, bit_cnt counts stop bits already sent
    assign tx_done = (state == STOP) && tick && (!stop2_q || bit_cnt[0]);

    // Hold the bit timer at zero whenever no timed bit is on the line
    always_comb begin
        baud_clear = (state == IDLE);
`ifdef UART_TX_BREAK_EN
        if (state == BREAK)
            baud_clear = 1'b1;
`endif
    end

    uart_baud_gen #(.DIV_W(DIV_W)) u_baud_gen (
        .clk     (clk),
        .reset   (reset),
        .clear   (baud_clear),
        .divisor (div_q),
        .tick    (tick)
    );

    // Frame sequencer with registered line output
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            tx_out    <= 1'b1;
            shift_q   <= '0;
            par_bit_q <= 1'b0;
            par_en_q  <= 1'b0;
            stop2_q   <= 1'b0;
            div_q     <= '0;
            bit_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tx_out <= 1'b1;
`ifdef UART_TX_BREAK_EN
                    if (send_break) begin
                        state  <= BREAK;
                        tx_out <= 1'b0;
                    end else
`endif
                    if (accept) begin
                        state     <= START;
                        tx_out    <= 1'b0;
                        shift_q   <= in_data;
                        par_bit_q <= (^in_data) ^ (parity_mode == PAR_ODD);
                        par_en_q  <= parity_enabled(parity_mode);
                        stop2_q   <= stop_sel;
                        div_q     <= baud_divisor;
                        bit_cnt   <= '0;
                    end
                end
                START: begin
                    if (tick) begin
                        state  <= DATA;
                        tx_out <= shift_q[0];
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            if (par_en_q) begin
                                state  <= PARITY;
                                tx_out <= par_bit_q;
                            end else begin
                                state  <= STOP;
                                tx_out <= 1'b1;
                            end
                        end else begin
                            shift_q <= shift_q >> 1;
                            tx_out  <= shift_q[1];
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end
                PARITY: begin
                    if (tick) begin
                        state   <= STOP;
                        tx_out  <= 1'b1;
                        bit_cnt <= '0;
                    end
                end
                STOP: begin
                    if (tx_done)
                        state <= IDLE;
                    else if (tick)
                        bit_cnt <= bit_cnt + CNT_W'(1);
                end
`ifdef UART_TX_BREAK_EN
                BREAK: begin
                    tx_out <= 1'b0;
                    if (!send_break) begin
                        state  <= MARK;
                        tx_out <= 1'b1;
                        div_q  <= baud_divisor;
                    end
                end
                MARK: begin
                    if (tick)
                        state <= IDLE;
                end
`endif
                default: begin
                    state  <= IDLE;
                    tx_out <= 1'b1;
                end
            endcase
        end
    end

endmodule
